sync_updown_mod_counter: RTL and testbench

Parametrised synchronous up/down modulo-N counter. It generalises the single toggle stage to a WIDTH-bit counter in which all bits update on one clock edge. It adds enable, direction, parallel load, synchronous clear, a wrap or saturate mode, and a terminal-count carry output. Stages cascade through cout into en, forming multi-digit counters such as BCD timers and frequency dividers.

---
 rtl/sync_updown_mod_counter.sv | 128 ++++++++++++
 tb/tb_sync_updown_mod_counter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sync_updown_mod_counter.sv
`default_nettype none
// ============================================================================
// Module      : sync_updown_mod_counter
// Description : Parametrised synchronous up/down modulo-MODULUS counter.
//               All WIDTH bits update on the same rising edge of clk.
//               Supports enable, direction, parallel load with range check,
//               synchronous clear, and wrap or saturate at the bounds.
//               A combinational terminal-count flag (tc) and cascade carry
//               (cout = en & tc) let stages chain into multi-digit counters.
// Ports       :
//   clk      in   1      rising-edge clock
//   rst      in   1      asynchronous reset, active high
//   clr      in   1      synchronous clear to 0 (highest priority)
//   load     in   1      synchronous parallel load
//   load_val in   WIDTH  value to load (out-of-range loads clamp to MODULUS-1)
//   en       in   1      count enable / cascade input
//   up_dn    in   1      1 = count up, 0 = count down
//   count    out  WIDTH  registered count value
//   tc       out  1      combinational terminal-count flag
//   cout     out  1      combinational cascade carry (en & tc)
//   wrapped  out  1      registered one-cycle pulse after a wrap
//   load_err out  1      registered one-cycle pulse after out-of-range load
// Revision    : 1.0 - initial release
// ============================================================================
module sync_updown_mod_counter #(
  parameter int unsigned     WIDTH    = 4,
  parameter longint unsigned MODULUS  = 10,
  parameter bit              SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up_dn,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             cout,
  output logic             wrapped,
  output logic             load_err
);

  // MODULUS may equal 2**WIDTH, which does not fit in WIDTH bits, so every
  // bound comparison is made against MODULUS-1 rather than MODULUS.
  localparam logic [WIDTH-1:0] C_MAX  = WIDTH'(MODULUS - 64'd1);
  localparam logic [WIDTH-1:0] C_ZERO = '0;
  localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrapped_q, wrapped_d;
  logic             load_err_q, load_err_d;

  logic             at_max;
  logic             at_min;
  logic             sat_mode;

  assign at_max = (count_q == C_MAX);
  assign at_min = (count_q == C_ZERO);

  // Mode selection is static; the labelled generate keeps the choice visible
  // in the elaborated hierarchy.
  generate
    if (SATURATE) begin : g_saturate
      assign sat_mode = 1'b1;
    end else begin : g_wrap
      assign sat_mode = 1'b0;
    end
  endgenerate

  // Next-state logic: clr > load > en > hold.
  always_comb begin
    count_d    = count_q;
    wrapped_d  = 1'b0;
    load_err_d = 1'b0;

    if (clr) begin
      count_d = C_ZERO;
    end else if (load) begin
      // load_val <= MODULUS-1 is the in-range test; it avoids forming
      // MODULUS itself in WIDTH bits.
      if (load_val <= C_MAX) begin
        count_d = load_val;
      end else begin
        count_d    = C_MAX;
        load_err_d = 1'b1;
      end
    end else if (en) begin
      if (up_dn) begin
        if (!at_max) begin
          count_d = count_q + C_ONE;
        end else if (!sat_mode) begin
          count_d   = C_ZERO;
          wrapped_d = 1'b1;
        end
      end else begin
        if (!at_min) begin
          count_d = count_q - C_ONE;
        end else if (!sat_mode) begin
          count_d   = C_MAX;
          wrapped_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= C_ZERO;
      wrapped_q  <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wrapped_q  <= wrapped_d;
      load_err_q <= load_err_d;
    end
  end

  // Terminal count looks at the bound in the current direction, so a
  // direction change is reflected with zero latency.
  assign tc       = up_dn ? at_max : at_min;
  assign cout     = en & tc;
  assign count    = count_q;
  assign wrapped  = wrapped_q;
  assign load_err = load_err_q;

endmodule
`default_nettype wire

// File: tb/tb_sync_updown_mod_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_updown_mod_counter
// Description : Self-checking bench for sync_updown_mod_counter. Directed
//               vector tables for a wrapping decade counter, a saturating
//               decade counter and a full-range (MODULUS=2**WIDTH) counter,
//               plus hand-written reset and two-digit cascade sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_updown_mod_counter;

  typedef struct {
    logic       clr;
    logic       load;
    logic [3:0] load_val;
    logic       en;
    logic       up_dn;
    logic [3:0] exp_count;
    logic       exp_tc;
    logic       exp_wrapped;
    logic       exp_load_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // per-instance stimulus/response: index 0 = wrap M10, 1 = sat M10, 2 = M16
  logic       d_clr  [3];
  logic       d_load [3];
  logic [3:0] d_lval [3];
  logic       d_en   [3];
  logic       d_up   [3];
  logic [3:0] q_count[3];
  logic       q_tc   [3];
  logic       q_cout [3];
  logic       q_wrap [3];
  logic       q_lerr [3];

  sync_updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .clr(d_clr[0]), .load(d_load[0]), .load_val(d_lval[0]),
    .en(d_en[0]), .up_dn(d_up[0]), .count(q_count[0]), .tc(q_tc[0]),
    .cout(q_cout[0]), .wrapped(q_wrap[0]), .load_err(q_lerr[0]));

  sync_updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .clr(d_clr[1]), .load(d_load[1]), .load_val(d_lval[1]),
    .en(d_en[1]), .up_dn(d_up[1]), .count(q_count[1]), .tc(q_tc[1]),
    .cout(q_cout[1]), .wrapped(q_wrap[1]), .load_err(q_lerr[1]));

  sync_updown_mod_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) u_pow2 (
    .clk(clk), .rst(rst), .clr(d_clr[2]), .load(d_load[2]), .load_val(d_lval[2]),
    .en(d_en[2]), .up_dn(d_up[2]), .count(q_count[2]), .tc(q_tc[2]),
    .cout(q_cout[2]), .wrapped(q_wrap[2]), .load_err(q_lerr[2]));

  // two-digit cascade: units cout drives tens en
  logic       c_en = 1'b0;
  logic [3:0] c_units, c_tens;
  logic       c_units_tc, c_units_cout, c_units_wrap, c_units_lerr;
  logic       c_tens_tc, c_tens_cout, c_tens_wrap, c_tens_lerr;

  sync_updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_units (
    .clk(clk), .rst(rst), .clr(1'b0), .load(1'b0), .load_val(4'd0),
    .en(c_en), .up_dn(1'b1), .count(c_units), .tc(c_units_tc),
    .cout(c_units_cout), .wrapped(c_units_wrap), .load_err(c_units_lerr));

  sync_updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_tens (
    .clk(clk), .rst(rst), .clr(1'b0), .load(1'b0), .load_val(4'd0),
    .en(c_units_cout), .up_dn(1'b1), .count(c_tens), .tc(c_tens_tc),
    .cout(c_tens_cout), .wrapped(c_tens_wrap), .load_err(c_tens_lerr));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic vec_t mk(input logic clr, input logic load, input logic [3:0] lv,
                              input logic en, input logic up, input logic [3:0] c,
                              input logic t, input logic w, input logic le);
    vec_t v;
    v.clr = clr; v.load = load; v.load_val = lv; v.en = en; v.up_dn = up;
    v.exp_count = c; v.exp_tc = t; v.exp_wrapped = w; v.exp_load_err = le;
    return v;
  endfunction

  // Drive one vector at the falling edge, sample 1 time unit after the
  // following rising edge while the inputs are still applied.
  task automatic apply_vec(input int sel, input string tag, input int idx, input vec_t v);
    @(negedge clk);
    d_clr[sel] = v.clr; d_load[sel] = v.load; d_lval[sel] = v.load_val;
    d_en[sel] = v.en; d_up[sel] = v.up_dn;
    @(posedge clk);
    #1;
    check($sformatf("%s[%0d].count", tag, idx), 32'(q_count[sel]), 32'(v.exp_count));
    check($sformatf("%s[%0d].tc", tag, idx), 32'(q_tc[sel]), 32'(v.exp_tc));
    check($sformatf("%s[%0d].cout", tag, idx), 32'(q_cout[sel]), 32'(v.en & v.exp_tc));
    check($sformatf("%s[%0d].wrapped", tag, idx), 32'(q_wrap[sel]), 32'(v.exp_wrapped));
    check($sformatf("%s[%0d].load_err", tag, idx), 32'(q_lerr[sel]), 32'(v.exp_load_err));
  endtask

  vec_t wrap_tbl[$];
  vec_t sat_tbl[$];
  vec_t pow_tbl[$];

  initial begin
    for (int i = 0; i < 3; i++) begin
      d_clr[i] = 1'b0; d_load[i] = 1'b0; d_lval[i] = 4'd0; d_en[i] = 1'b0; d_up[i] = 1'b1;
    end

    // ---------------- tables ----------------
    //                  clr load val en up  cnt tc w  le
    wrap_tbl.push_back(mk(1, 0, 4'd0, 0, 1, 4'd0, 0, 0, 0));
    for (int k = 1; k <= 12; k++)
      wrap_tbl.push_back(mk(0, 0, 4'd0, 1, 1, 4'((k % 10)), (k % 10) == 9, (k == 10), 0));
    wrap_tbl.push_back(mk(0, 1, 4'd2, 0, 0, 4'd2, 0, 0, 0));
    wrap_tbl.push_back(mk(0, 0, 4'd0, 1, 0, 4'd1, 0, 0, 0));
    wrap_tbl.push_back(mk(0, 0, 4'd0, 1, 0, 4'd0, 1, 0, 0));
    wrap_tbl.push_back(mk(0, 0, 4'd0, 1, 0, 4'd9, 0, 1, 0));
    wrap_tbl.push_back(mk(0, 0, 4'd0, 1, 0, 4'd8, 0, 0, 0));
    wrap_tbl.push_back(mk(0, 0, 4'd0, 1, 1, 4'd9, 1, 0, 0));
    wrap_tbl.push_back(mk(0, 1, 4'd12, 1, 1, 4'd9, 1, 0, 1));
    wrap_tbl.push_back(mk(0, 0, 4'd0, 0, 1, 4'd9, 1, 0, 0));
    wrap_tbl.push_back(mk(0, 1, 4'd4, 1, 1, 4'd4, 0, 0, 0));
    wrap_tbl.push_back(mk(1, 1, 4'd6, 1, 1, 4'd0, 0, 0, 0));
    wrap_tbl.push_back(mk(0, 0, 4'd0, 1, 0, 4'd9, 0, 1, 0));
    wrap_tbl.push_back(mk(1, 0, 4'd0, 0, 0, 4'd0, 1, 0, 0));
    wrap_tbl.push_back(mk(0, 1, 4'd9, 0, 1, 4'd9, 1, 0, 0));
    wrap_tbl.push_back(mk(0, 1, 4'd10, 0, 1, 4'd9, 1, 0, 1));
    wrap_tbl.push_back(mk(0, 0, 4'd0, 1, 1, 4'd0, 0, 1, 0));

    sat_tbl.push_back(mk(0, 1, 4'd7, 0, 1, 4'd7, 0, 0, 0));
    sat_tbl.push_back(mk(0, 0, 4'd0, 1, 1, 4'd8, 0, 0, 0));
    for (int k = 0; k < 4; k++)
      sat_tbl.push_back(mk(0, 0, 4'd0, 1, 1, 4'd9, 1, 0, 0));
    sat_tbl.push_back(mk(0, 0, 4'd0, 0, 1, 4'd9, 1, 0, 0));
    sat_tbl.push_back(mk(1, 0, 4'd0, 0, 0, 4'd0, 1, 0, 0));
    sat_tbl.push_back(mk(0, 0, 4'd0, 1, 0, 4'd0, 1, 0, 0));
    sat_tbl.push_back(mk(0, 0, 4'd0, 1, 0, 4'd0, 1, 0, 0));
    sat_tbl.push_back(mk(0, 1, 4'd15, 0, 1, 4'd9, 1, 0, 1));

    pow_tbl.push_back(mk(0, 0, 4'd0, 1, 0, 4'd15, 0, 1, 0));
    pow_tbl.push_back(mk(0, 0, 4'd0, 1, 1, 4'd0, 0, 1, 0));
    pow_tbl.push_back(mk(0, 0, 4'd0, 1, 1, 4'd1, 0, 0, 0));
    pow_tbl.push_back(mk(0, 1, 4'd15, 0, 1, 4'd15, 1, 0, 0));
    pow_tbl.push_back(mk(0, 0, 4'd0, 1, 1, 4'd0, 0, 1, 0));
    pow_tbl.push_back(mk(0, 1, 4'd14, 1, 1, 4'd14, 0, 0, 0));
    pow_tbl.push_back(mk(0, 0, 4'd0, 1, 1, 4'd15, 1, 0, 0));

    // ---------------- reset behaviour ----------------
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold.count", 32'(q_count[0]), 0);
    @(negedge clk) rst = 1'b0;

    // load_err pending, then asynchronous reset between edges clears it
    apply_vec(0, "pre_rst", 0, mk(0, 1, 4'd12, 0, 0, 4'd9, 0, 0, 1));
    #2 rst = 1'b1; d_load[0] = 1'b0;
    #1;
    check("async_rst_a.count", 32'(q_count[0]), 0);
    check("async_rst_a.load_err", 32'(q_lerr[0]), 0);
    check("async_rst_a.tc_down", 32'(q_tc[0]), 1);

    @(negedge clk) rst = 1'b0;
    apply_vec(0, "pre_rst", 1, mk(0, 1, 4'd7, 0, 1, 4'd7, 0, 0, 0));
    #2 rst = 1'b1; d_load[0] = 1'b0; d_en[0] = 1'b0;
    #1;
    check("async_rst_b.count", 32'(q_count[0]), 0);
    check("async_rst_b.wrapped", 32'(q_wrap[0]), 0);
    check("async_rst_b.load_err", 32'(q_lerr[0]), 0);
    check("async_rst_b.tc_up", 32'(q_tc[0]), 0);
    @(negedge clk);
    rst = 1'b0; d_en[0] = 1'b1; d_up[0] = 1'b1;
    @(posedge clk);
    #1;
    check("first_edge.count", 32'(q_count[0]), 1);

    // ---------------- table-driven vectors ----------------
    foreach (wrap_tbl[i]) apply_vec(0, "wrap", i, wrap_tbl[i]);
    foreach (sat_tbl[i])  apply_vec(1, "sat", i, sat_tbl[i]);
    foreach (pow_tbl[i])  apply_vec(2, "pow2", i, pow_tbl[i]);

    // ---------------- two-digit cascade ----------------
    @(negedge clk) c_en = 1'b1;
    for (int k = 1; k <= 99; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("cascade[%0d].digits", k), {24'd0, c_tens, c_units},
            {24'd0, 4'(k / 10), 4'(k % 10)});
      if (k == 98) check("cascade[98].tens_cout", 32'(c_tens_cout), 0);
    end
    check("cascade[99].units_cout", 32'(c_units_cout), 1);
    check("cascade[99].tens_cout", 32'(c_tens_cout), 1);
    @(posedge clk);
    #1;
    check("cascade[100].digits", {24'd0, c_tens, c_units}, 0);
    check("cascade[100].tens_wrapped", 32'(c_tens_wrap), 1);
    check("cascade[100].units_wrapped", 32'(c_units_wrap), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
